// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//    Characterises a combinational N_IN-input, 1-output block. Drives every
//    input combination in ascending order, holds each one for SETTLE cycles,
//    samples the block's response on the edge closing the last held cycle,
//    and assembles the full truth table (tt[k] = response to drv == k).
//
// Parameters:
//    N_IN    number of inputs driven on the block under test (1..8)
//    SETTLE  cycles each vector is held before sampling (>= 1)
//    TT_W    derived truth-table width, 2**N_IN (not overridden)
//
// Ports:
//    clk       in   rising-edge clock
//    rst       in   asynchronous, active-high reset
//    start     in   begin a sweep (accepted only when idle, abort low)
//    abort     in   cancel a sweep in progress
//    drv       out  vector driven on the block; drv[N_IN-1] is the first input
//    resp      in   output of the block under test
//    busy      out  sweep in progress
//    done      out  one-cycle pulse when the table is complete
//    tt        out  captured truth table
//    tt_valid  out  tt holds a complete sweep
//
// Optional feature (macro TT_COMPARE_EN):
//    expected  in   reference truth table
//    match     out  captured table equals expected (set on completion,
//                   cleared by an accepted start or by abort)
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter  int N_IN   = 4,
   parameter  int SETTLE = 2,
   localparam int TT_W   = 2 ** N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] drv,
   input  logic            resp,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] tt,
   output logic            tt_valid
`ifdef TT_COMPARE_EN
   ,
   input  logic [TT_W-1:0] expected,
   output logic            match
`endif
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(TT_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q,   idx_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [TT_W-1:0]   tt_q,    tt_d;
   logic              tt_valid_q, tt_valid_d;
`ifdef TT_COMPARE_EN
   logic              match_q, match_d;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop; blocking here would create
   // order-dependent simulation and mismatch synthesis.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         tt_q       <= '0;
         tt_valid_q <= 1'b0;
`ifdef TT_COMPARE_EN
         match_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         tt_q       <= tt_d;
         tt_valid_q <= tt_valid_d;
`ifdef TT_COMPARE_EN
         match_q    <= match_d;
`endif
      end
   end

   // NOTE: every next-state variable is given its hold value before the case
   // statement, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      tt_d       = tt_q;
      tt_valid_d = tt_valid_q;
`ifdef TT_COMPARE_EN
      match_d    = match_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            // abort has priority over start when both are high
            if (start && !abort) begin
               state_d    = S_DRIVE;
               idx_d      = '0;
               cnt_d      = '0;
               tt_d       = '0;
               tt_valid_d = 1'b0;
`ifdef TT_COMPARE_EN
               match_d    = 1'b0;
`endif
            end
         end

         S_DRIVE: begin
            if (abort) begin
               // partial bits stay in tt but are flagged invalid
               state_d    = S_IDLE;
               idx_d      = '0;
               cnt_d      = '0;
               tt_valid_d = 1'b0;
`ifdef TT_COMPARE_EN
               match_d    = 1'b0;
`endif
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // last held cycle of this vector: capture the response
               tt_d[idx_q] = resp;
               cnt_d       = '0;
               if (idx_q == IDX_LAST) begin
                  state_d    = S_DONE;
                  idx_d      = '0;
                  tt_valid_d = 1'b1;
`ifdef TT_COMPARE_EN
                  // compare against the table including the bit just sampled
                  match_d    = (tt_d == expected);
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state, so an asynchronous reset
   // clears them immediately.
   assign drv      = (state_q == S_DRIVE) ? idx_q : '0;
   assign busy     = (state_q == S_DRIVE);
   assign done     = (state_q == S_DONE);
   assign tt       = tt_q;
   assign tt_valid = tt_valid_q;
`ifdef TT_COMPARE_EN
   assign match    = match_q;
`endif

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus/capture engine that characterises a combinational N-input, 1-output logic block. It drives every input combination in ascending order, waits a programmable settle time, samples the block's output, and assembles the full truth table into a register. It is the measuring end of the truth-table interface: it reads the function back out of a circuit, rather than evaluating one. It sits beside the circuit under test in characterisation and self-check benches.

Parameters:
N_IN, 4, number of inputs driven on the block under test (1..8)
SETTLE, 2, cycles each input vector is held before sampling (>=1)
TT_W, 2**N_IN, derived truth-table width; not overridden

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  cancel sweep in progress
drv  output  N_IN  input vector to block under test; drv[N_IN-1] = first input (inp1), drv[0] = last input
resp  input  1  output of block under test
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when the table is complete
tt  output  TT_W  captured truth table; tt[k] = response to drv==k
tt_valid  output  1  tt holds a complete sweep

Behaviour:
- Reset (async, rst=1): state=IDLE; drv=0, busy=0, done=0, tt=0, tt_valid=0, idx=0, cnt=0. Asserting rst mid-sweep clears all of these immediately, without waiting for a clock edge.
- States: IDLE, DRIVE, DONE.
- IDLE: drv=0, busy=0. On an edge with start=1 and abort=0:
  - go to DRIVE with idx=0, cnt=0, tt=0, tt_valid=0.
  - If start and abort are both 1, abort wins and start is ignored.
- DRIVE:
  - busy=1 and drv=idx.
  - Each edge with cnt<SETTLE-1: cnt++.
  - Edge with cnt==SETTLE-1: tt[idx]<=resp (value present just before the edge); cnt<=0.
  - Then, if idx==TT_W-1, go to DONE; otherwise idx++.
  - Each vector is therefore stable for exactly SETTLE cycles. resp is sampled at the edge closing the vector's last cycle.
- Latency: start accepted at edge E0. Row k is sampled at edge E((k+1)*SETTLE). done is high in the cycle after edge E(TT_W*SETTLE).
- DONE (one cycle): done=1, busy=0, tt_valid=1, drv=0. Next edge goes to IDLE. start is ignored in DONE.
- tt_valid stays 1 and tt is held until the next accepted start or until reset.
- start while busy: ignored; no restart, no change in timing.
- abort=1 on any edge in DRIVE:
  - go to IDLE next cycle with drv=0, busy=0, tt_valid=0, no done pulse.
  - tt keeps any partial bits, but those bits are invalid.
- abort in IDLE or DONE: no effect, except that in DONE it does not clear tt_valid.
- idx is N_IN bits plus a terminal compare; it never wraps past TT_W-1.

Optional Feature:
Macro TT_COMPARE_EN.
- Defined:
  - Adds input expected[TT_W] and output match[1] (reset 0).
  - On the DONE transition edge, match<=(captured table == expected), using the final bit just sampled.
  - match is held until the next accepted start, which clears it to 0.
  - abort clears it to 0.
- Undefined: neither port exists and no comparator is built.

Test Plan:
- Golden model f=1 only for rows 8,9,14,15 (inp1..inp4 order), SETTLE=2, start pulse -> drv steps 0..15, each held exactly 2 cycles; done one cycle after edge E32; tt=16'hC300; tt_valid=1; busy low in the done cycle.
- resp tied 0 -> tt=16'h0000. resp tied 1 -> tt=16'hFFFF. SETTLE=1 -> done after E16 with the same results.
- start re-pulsed at row 3 and again in the DONE cycle -> ignored; done still after E32; tt=16'hC300; no second sweep.
- abort during row 5 -> busy=0, drv=0, tt_valid=0 next cycle, no done. Fresh start -> full correct sweep, tt=16'hC300.
- rst pulsed between edges mid-sweep -> drv, busy, tt, tt_valid go to 0 before the next edge. After release, IDLE until start.
- TT_COMPARE_EN with expected=16'hC300 -> match=1 in the done cycle. With expected=16'hC301 -> match=0. Next start -> match=0.
